tb_mem_rsp: RTL and testbench

// - Parametrised memory responder for the TTW memory port. Sits in the fs bench, on the DUT side opposite mem_req_o/mem_res_i.
// - Accepts line requests (idx, mcn) on N_CH independent channels and buffers up to DEPTH per channel.
// - Returns a deterministic data line per request after a programmable latency, with ready/valid backpressure on both sides.

---
 rtl/tb_mem_rsp.sv | 204 ++++++++++++++++++++
 tb/tb_tb_mem_rsp.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mem_rsp.sv
// tb_mem_rsp -- memory responder for the TTW memory port (bench side).
//
// Accepts line requests (idx, mcn) on N_CH independent channels, holds up to
// DEPTH outstanding requests per channel and answers each one with a
// deterministic data line after a programmable latency. Ready/valid
// backpressure is supported on both the request and the response side.
//
// Ports
//   clock            bench clock, all state on posedge
//   reset            synchronous, active-low
//   stall_i          per-channel: force req_i_ready low (takes effect next cycle)
//   req_i_valid      per-channel request valid
//   req_i_ready      per-channel request ready (registered)
//   req_i_bits_idx   request tag, channel c at [c*IDX_W +: IDX_W]
//   req_i_bits_mcn   request cache-line number, channel c at [c*MCN_W +: MCN_W]
//   res_o_valid      per-channel response valid (registered)
//   res_o_ready      per-channel response ready
//   res_o_bits_idx   response tag (tag of the request being answered)
//   res_o_bits_data  response line; 64-bit word j = {j[5:0], mcn zero-extended to 58b}
//   busy_o           any slot on any channel occupied (registered)
//
// Build option
//   TB_MEM_RSP_OOO_EN  undefined: FIFO order, fixed latency LAT.
//                      defined:   free-list slots, latency LAT + lfsr[2:0],
//                                 lowest-numbered eligible slot issues first.

module tb_mem_rsp #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned MCN_W  = 58,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LAT    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          stall_i,
  input  logic [N_CH-1:0]          req_i_valid,
  output logic [N_CH-1:0]          req_i_ready,
  input  logic [N_CH*IDX_W-1:0]    req_i_bits_idx,
  input  logic [N_CH*MCN_W-1:0]    req_i_bits_mcn,
  output logic [N_CH-1:0]          res_o_valid,
  input  logic [N_CH-1:0]          res_o_ready,
  output logic [N_CH*IDX_W-1:0]    res_o_bits_idx,
  output logic [N_CH*DATA_W-1:0]   res_o_bits_data,
  output logic                     busy_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned AGE_W  = $clog2(LAT + 8) + 1;
  localparam int unsigned N_WORD = DATA_W / 64;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  function automatic logic [DATA_W-1:0] line_of(input logic [MCN_W-1:0] mcn);
    logic [DATA_W-1:0] l;
    l = '0;
    for (int unsigned j = 0; j < N_WORD; j++) begin
      l[j*64 +: 64] = {6'(j), 58'(mcn)};
    end
    return l;
  endfunction

  logic [N_CH-1:0] nonempty_d;
  logic            busy_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [IDX_W-1:0]  idx_q [DEPTH];
    logic [MCN_W-1:0]  mcn_q [DEPTH];
    logic [AGE_W-1:0]  age_q [DEPTH];
    logic [AGE_W-1:0]  tgt_q [DEPTH];
    logic [DEPTH-1:0]  occ_q;
    logic [DEPTH-1:0]  iss_q;   // slot currently loaded into the response register
    logic [DEPTH-1:0]  elig;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q, vld_q;
    logic [IDX_W-1:0]  ridx_q;
    logic [DATA_W-1:0] rdata_q;
    logic [PTR_W-1:0]  rslot_q;
    logic              acc, rel, sel_vld;
    logic [PTR_W-1:0]  sel, wslot;
    logic [AGE_W-1:0]  new_tgt;
`ifdef TB_MEM_RSP_OOO_EN
    logic [7:0]        lfsr_q;
    logic              wfound;
`else
    logic [PTR_W-1:0]  wr_q, rd_q;
`endif

    assign acc   = req_i_valid[c] && rdy_q;
    assign rel   = vld_q && res_o_ready[c];
    assign cnt_d = cnt_q + CNT_W'(acc) - CNT_W'(rel);

    // Eligibility looks at the age the slot will have after this edge, so a
    // slot accepted at edge t is presented as valid right after edge t+target.
    always_comb begin
      elig = '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        elig[s] = ({1'b0, age_q[s]} + (AGE_W+1)'(1)) >= {1'b0, tgt_q[s]};
      end
    end

    always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      wslot   = '0;
      new_tgt = AGE_W'(LAT);
`ifdef TB_MEM_RSP_OOO_EN
      wfound  = 1'b0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        if (!sel_vld && occ_q[s] && !iss_q[s] && elig[s]) begin
          sel     = PTR_W'(s);
          sel_vld = 1'b1;
        end
        if (!wfound && !occ_q[s]) begin
          wslot  = PTR_W'(s);
          wfound = 1'b1;
        end
      end
      new_tgt = AGE_W'(LAT) + AGE_W'(lfsr_q[2:0]);
`else
      // On a handshake the head moves on this edge, so look one slot ahead.
      sel     = rel ? rd_q + PTR_W'(1) : rd_q;
      sel_vld = occ_q[sel] && !iss_q[sel] && elig[sel];
      wslot   = wr_q;
`endif
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        occ_q   <= '0;
        iss_q   <= '0;
        cnt_q   <= '0;
        rdy_q   <= 1'b0;
        vld_q   <= 1'b0;
        ridx_q  <= '0;
        rdata_q <= '0;
        rslot_q <= '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
          idx_q[s] <= '0;
          mcn_q[s] <= '0;
          age_q[s] <= '0;
          tgt_q[s] <= '0;
        end
`ifdef TB_MEM_RSP_OOO_EN
        lfsr_q  <= 8'h5A ^ 8'(c);
`else
        wr_q    <= '0;
        rd_q    <= '0;
`endif
      end else begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          if (occ_q[s] && age_q[s] != AGE_MAX) age_q[s] <= age_q[s] + AGE_W'(1);
        end
        if (rel) begin
          occ_q[rslot_q] <= 1'b0;
          iss_q[rslot_q] <= 1'b0;
`ifndef TB_MEM_RSP_OOO_EN
          rd_q <= rd_q + PTR_W'(1);
`endif
        end
        // Accept only happens with a free slot; it never collides with the
        // slot released on the same edge, which is still occupied.
        if (acc) begin
          occ_q[wslot] <= 1'b1;
          idx_q[wslot] <= req_i_bits_idx[c*IDX_W +: IDX_W];
          mcn_q[wslot] <= req_i_bits_mcn[c*MCN_W +: MCN_W];
          age_q[wslot] <= '0;
          tgt_q[wslot] <= new_tgt;
`ifdef TB_MEM_RSP_OOO_EN
          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
          wr_q   <= wr_q + PTR_W'(1);
`endif
        end
        if (!vld_q || rel) begin
          vld_q <= sel_vld;
          if (sel_vld) begin
            ridx_q     <= idx_q[sel];
            rdata_q    <= line_of(mcn_q[sel]);
            rslot_q    <= sel;
            iss_q[sel] <= 1'b1;
          end
        end
        cnt_q <= cnt_d;
        rdy_q <= (cnt_d != CNT_W'(DEPTH)) && !stall_i[c];
      end
    end

    assign nonempty_d[c]                        = (cnt_d != '0);
    assign req_i_ready[c]                       = rdy_q;
    assign res_o_valid[c]                       = vld_q;
    assign res_o_bits_idx[c*IDX_W +: IDX_W]     = ridx_q;
    assign res_o_bits_data[c*DATA_W +: DATA_W]  = rdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) busy_q <= 1'b0;
    else        busy_q <= |nonempty_d;
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_tb_mem_rsp.sv
// Self-checking bench for tb_mem_rsp: table-driven single requests plus
// hand-written sequences for full/backpressure/stall/reset corner cases.
// A scoreboard queue holds every accepted request; responses are checked
// against it on every cycle they are presented.
module tb_tb_mem_rsp;
  localparam int unsigned N_CH   = 2;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned MCN_W  = 58;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned LAT    = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_CH-1:0]        stall, req_valid, req_ready, res_valid, res_ready;
  logic [N_CH*IDX_W-1:0]  req_idx, res_idx;
  logic [N_CH*MCN_W-1:0]  req_mcn;
  logic [N_CH*DATA_W-1:0] res_data;
  logic                   busy;

  tb_mem_rsp #(
    .N_CH(N_CH), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .MCN_W(MCN_W), .DATA_W(DATA_W), .LAT(LAT)
  ) dut (
    .clock(clock), .reset(reset), .stall_i(stall),
    .req_i_valid(req_valid), .req_i_ready(req_ready),
    .req_i_bits_idx(req_idx), .req_i_bits_mcn(req_mcn),
    .res_o_valid(res_valid), .res_o_ready(res_ready),
    .res_o_bits_idx(res_idx), .res_o_bits_data(res_data),
    .busy_o(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned      ch;
    logic [IDX_W-1:0] idx;
    logic [MCN_W-1:0] mcn;
    int unsigned      acc;
  } sb_t;

  typedef struct {
    int unsigned      ch;
    logic [IDX_W-1:0] idx;
    logic [MCN_W-1:0] mcn;
    logic [63:0]      w0;
    logic [63:0]      w7;
  } vec_t;

  sb_t              sbq[$];
  int unsigned      n_vec = 0, n_err = 0, cyc = 0;
  int unsigned      outst[N_CH], max_out[N_CH], acc_total[N_CH];
  int unsigned      rise[N_CH], last_lat[N_CH];
  logic [N_CH-1:0]  pres = '0;
  logic [IDX_W-1:0] last_idx[N_CH];
  logic [DATA_W-1:0] last_data[N_CH];
  int unsigned      ret_cnt[4];

  always @(posedge clock) cyc = cyc + 1;

  function automatic logic [DATA_W-1:0] exp_line(input logic [MCN_W-1:0] mcn);
    logic [DATA_W-1:0] l;
    logic [63:0]       w;
    l = '0;
    for (int j = 0; j < DATA_W/64; j++) begin
      w = 64'(mcn);
      w[63:58] = 6'(j);
      l[j*64 +: 64] = w;
    end
    return l;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int unsigned count_ch(input int unsigned ch);
    int unsigned n;
    n = 0;
    foreach (sbq[i]) if (sbq[i].ch == ch) n++;
    return n;
  endfunction

  // Scoreboard monitor, sampling at negedge (inputs are driven #1 after posedge).
  always @(negedge clock) begin : mon
    int k;
    if (!reset) begin
      sbq.delete();
      pres = '0;
      for (int c = 0; c < N_CH; c++) outst[c] = 0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          sbq.push_back('{ch: c, idx: req_idx[c*IDX_W +: IDX_W],
                          mcn: req_mcn[c*MCN_W +: MCN_W], acc: cyc + 1});
          outst[c]++;
          acc_total[c]++;
          if (outst[c] > max_out[c]) max_out[c] = outst[c];
        end
        if (res_valid[c]) begin
          k = -1;
          foreach (sbq[i]) begin
`ifdef TB_MEM_RSP_OOO_EN
            if (k < 0 && sbq[i].ch == c && sbq[i].idx == res_idx[c*IDX_W +: IDX_W]) k = i;
`else
            if (k < 0 && sbq[i].ch == c) k = i;
`endif
          end
          if (k < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious response ch%0d: got idx %0d want none", c, res_idx[c*IDX_W +: IDX_W]);
          end else begin
            if (!pres[c]) begin
              pres[c] = 1'b1;
              rise[c] = cyc;
            end
            chk("rsp idx", DATA_W'(res_idx[c*IDX_W +: IDX_W]), DATA_W'(sbq[k].idx));
            chk("rsp data", res_data[c*DATA_W +: DATA_W], exp_line(sbq[k].mcn));
            if (res_ready[c]) begin
              last_lat[c]  = rise[c] - sbq[k].acc;
              last_idx[c]  = res_idx[c*IDX_W +: IDX_W];
              last_data[c] = res_data[c*DATA_W +: DATA_W];
              chki("rsp latency >= LAT", int'(last_lat[c] >= LAT), 1);
`ifdef TB_MEM_RSP_OOO_EN
              chki("rsp latency <= LAT+7", int'(last_lat[c] <= LAT + 7), 1);
`endif
              ret_cnt[sbq[k].idx]++;
              sbq.delete(k);
              outst[c]--;
              pres[c] = 1'b0;
            end
          end
        end else begin
          pres[c] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int unsigned ch, input logic [IDX_W-1:0] idx, input logic [MCN_W-1:0] mcn);
    req_idx[ch*IDX_W +: IDX_W] = idx;
    req_mcn[ch*MCN_W +: MCN_W] = mcn;
  endtask

  task automatic send(input int unsigned ch, input logic [IDX_W-1:0] idx, input logic [MCN_W-1:0] mcn);
    int unsigned t;
    logic        got;
    t = 0;
    got = 1'b0;
    drive(ch, idx, mcn);
    req_valid[ch] = 1'b1;
    while (!got && t < 40) begin
      @(negedge clock);
      got = req_ready[ch];
      step();
      t++;
    end
    req_valid[ch] = 1'b0;
    chki("request accepted in time", int'(got), 1);
  endtask

  task automatic drain(input int unsigned ch, input int unsigned budget);
    int unsigned t;
    t = 0;
    while (count_ch(ch) != 0 && t < budget) begin
      step();
      t++;
    end
    step();
    chki("responses drained in time", int'(count_ch(ch)), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    step();
  endtask

  vec_t vecs[4];

  initial begin
    int unsigned a0, a1;
    vecs[0] = '{0, 2'd1, 58'h123,               64'h0000_0000_0000_0123, 64'h1C00_0000_0000_0123};
    vecs[1] = '{1, 2'd2, 58'h3FF_FFFF_FFFF_FFFF, 64'h03FF_FFFF_FFFF_FFFF, 64'h1FFF_FFFF_FFFF_FFFF};
    vecs[2] = '{0, 2'd3, 58'h0,                 64'h0000_0000_0000_0000, 64'h1C00_0000_0000_0000};
    vecs[3] = '{1, 2'd0, 58'h2AA_AAAA_AAAA_AAAA, 64'h02AA_AAAA_AAAA_AAAA, 64'h1EAA_AAAA_AAAA_AAAA};
    for (int c = 0; c < N_CH; c++) begin
      outst[c] = 0; max_out[c] = 0; acc_total[c] = 0; rise[c] = 0; last_lat[c] = 0;
    end
    for (int i = 0; i < 4; i++) ret_cnt[i] = 0;
    reset = 1'b0; stall = '0; req_valid = '0; req_idx = '0; req_mcn = '0; res_ready = '0;
    repeat (3) step();

    // Outputs held at zero during reset.
    chki("reset req_ready", int'(req_ready), 0);
    chki("reset res_valid", int'(res_valid), 0);
    chki("reset busy", int'(busy), 0);
    chk("reset res_idx", DATA_W'(res_idx), '0);
    chk("reset res_data", res_data[DATA_W-1:0], '0);
    reset = 1'b1;
    step();
    step();
    chki("ready after reset", int'(req_ready), 3);

    // Table: single request per entry, unobstructed response.
    res_ready = '1;
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].ch, vecs[v].idx, vecs[v].mcn);
      drain(vecs[v].ch, 40);
`ifdef TB_MEM_RSP_OOO_EN
      chki("vec latency in range", int'(last_lat[vecs[v].ch] >= LAT && last_lat[vecs[v].ch] <= LAT + 7), 1);
`else
      chki("vec latency", int'(last_lat[vecs[v].ch]), int'(LAT));
`endif
      chki("vec idx", int'(last_idx[vecs[v].ch]), int'(vecs[v].idx));
      chk("vec word0", DATA_W'(last_data[vecs[v].ch][63:0]), DATA_W'(vecs[v].w0));
      chk("vec word7", DATA_W'(last_data[vecs[v].ch][511:448]), DATA_W'(vecs[v].w7));
    end

`ifndef TB_MEM_RSP_OOO_EN
    // Fill ch0 with responses blocked, hold >20 cycles, then release one.
    res_ready = '0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive(0, 2'(acc_total[0]), 58'h100 + 58'(acc_total[0]));
      step();
    end
    chki("outstanding at full", int'(outst[0]), int'(DEPTH));
    chki("ready low when full", int'(req_ready[0]), 0);
    chki("busy when full", int'(busy), 1);
    chki("valid held under backpressure", int'(res_valid[0]), 1);
    res_ready[0] = 1'b1;
    step();
    res_ready[0] = 1'b0;
    chki("ready after one release", int'(req_ready[0]), 1);
    drive(0, 2'(acc_total[0]), 58'h100 + 58'(acc_total[0]));
    step();
    chki("ready low after refill", int'(req_ready[0]), 0);
    chki("never more than DEPTH outstanding", int'(max_out[0]), int'(DEPTH));
    req_valid[0] = 1'b0;
    res_ready[0] = 1'b1;
    drain(0, 80);
    chki("busy after drain", int'(busy), 0);

    // Both channels offered traffic, ch1 stalled: ch0 sustains 1/cycle.
    stall = 2'b10;
    res_ready = '1;
    step();
    step();
    chki("stalled ch1 not ready", int'(req_ready[1]), 0);
    a0 = acc_total[0];
    a1 = acc_total[1];
    req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      drive(0, 2'(acc_total[0]), 58'h400 + 58'(acc_total[0]));
      drive(1, 2'(i), 58'h800 + 58'(i));
      step();
    end
    req_valid = '0;
    chki("ch0 throughput", int'(acc_total[0] - a0), 20);
    chki("ch1 accepts nothing", int'(acc_total[1] - a1), 0);
    drain(0, 60);
    stall = '0;
`endif

    // Reset with 5 outstanding, then a fresh request after release.
    res_ready = '0;
    for (int i = 0; i < 5; i++) send(0, 2'(i), 58'h600 + 58'(i));
    chki("outstanding before reset", int'(outst[0]), 5);
    repeat (4) step();
    chki("valid before reset", int'(res_valid[0]), 1);
    reset = 1'b0;
    step();
    chki("valid dropped by reset", int'(res_valid), 0);
    chki("busy dropped by reset", int'(busy), 0);
    chki("ready dropped by reset", int'(req_ready), 0);
    reset = 1'b1;
    step();
    step();
    res_ready = '1;
    send(0, 2'd2, 58'h777);
    drain(0, 40);
`ifdef TB_MEM_RSP_OOO_EN
    chki("post-reset latency in range", int'(last_lat[0] >= LAT && last_lat[0] <= LAT + 7), 1);
`else
    chki("post-reset latency", int'(last_lat[0]), int'(LAT));
`endif
    chk("post-reset data", last_data[0], exp_line(58'h777));

`ifdef TB_MEM_RSP_OOO_EN
    // Four tags back-to-back: each returns exactly once.
    do_reset();
    for (int i = 0; i < 4; i++) ret_cnt[i] = 0;
    res_ready = '1;
    for (int i = 0; i < 4; i++) send(0, 2'(i), 58'h200 + 58'(i));
    drain(0, 80);
    for (int i = 0; i < 4; i++) chki("ooo tag returned once", int'(ret_cnt[i]), 1);
`else
    do_reset();
    chki("ready after second reset", int'(req_ready), 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule
